// File: rtl/multi_mode_timer.sv
// multi_mode_timer: prescaled down-counter, one-shot or auto-reload, sticky expiry flag.
// Latency: cnt moves on the tick edge; done/flag/pwm_out are registered (valid the cycle after).
// Backpressure: none; i_en pauses, i_stop holds, i_start reloads. Optional PWM via `TIMER_PWM_EN.
module multi_mode_timer #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,     // asynchronous, active low
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_one_shot,
  input  logic [PSC_W-1:0] i_psc,
  input  logic [CNT_W-1:0] i_reload,
  input  logic [CNT_W-1:0] i_cmp,
  input  logic             i_clr_flag,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_running,
  output logic             o_done,
  output logic             o_flag,
  output logic             o_pwm_out
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [PSC_W-1:0] r_psc_cnt;
  logic [PSC_W-1:0] r_psc_prev;
  logic             r_done;
  logic             r_flag;

  logic             w_running;
  logic             w_psc_chg;
  logic             w_advance;
  logic             w_tick;
  logic             w_cnt_zero;
  logic             w_expire;

  assign w_running  = (r_state == S_RUN);
  // A prescale value that differs from last cycle restarts the prescaler
  // and suppresses the tick for this cycle.
  assign w_psc_chg  = (i_psc != r_psc_prev);
  // start and stop outrank any tick in the same cycle.
  assign w_advance  = w_running & i_en & ~i_start & ~i_stop & ~w_psc_chg;
  assign w_tick     = w_advance & (r_psc_cnt == i_psc);
  assign w_cnt_zero = (r_cnt == '0);
  assign w_expire   = w_tick & w_cnt_zero;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start > stop > one-shot expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end else if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_expire && i_one_shot) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Remember last cycle's prescale value for change detection.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_psc_prev <= '0;
    end else begin
      r_psc_prev <= i_psc;
    end
  end

  // Prescaler: counts enabled RUN cycles, wraps on tick; held while paused or stopped.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_psc_cnt <= '0;
    end else if (i_start || w_psc_chg) begin
      r_psc_cnt <= '0;
    end else if (w_advance) begin
      r_psc_cnt <= w_tick ? '0 : (r_psc_cnt + PSC_ONE);
    end
  end

  // Main counter: reload on start, decrement on tick, reload or park at 0 on expiry.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_reload;
    end else if (w_tick) begin
      if (!w_cnt_zero) begin
        r_cnt <= r_cnt - CNT_ONE;
      end else if (!i_one_shot) begin
        r_cnt <= i_reload;
      end
    end
  end

  // Expiry pulse and sticky flag; a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_done <= 1'b0;
      r_flag <= 1'b0;
    end else begin
      r_done <= w_expire;
      if (w_expire) begin
        r_flag <= 1'b1;
      end else if (i_clr_flag) begin
        r_flag <= 1'b0;
      end
    end
  end

`ifdef TIMER_PWM_EN
  logic r_pwm;

  // PWM: high while running and the count sits below the compare value.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_running & (r_cnt < i_cmp);
    end
  end

  assign o_pwm_out = r_pwm;
`else
  // Compare input is not used without the PWM option.
  logic w_unused_cmp;
  assign w_unused_cmp = ^i_cmp;
  assign o_pwm_out    = 1'b0;
`endif

  assign o_cnt     = r_cnt;
  assign o_running = w_running;
  assign o_done    = r_done;
  assign o_flag    = r_flag;

endmodule

// File: tb/tb_multi_mode_timer.sv
// tb_multi_mode_timer: directed scenarios plus random stimulus against a behavioural model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: not applicable; inputs are driven right after each comparison.
module tb_multi_mode_timer;

  localparam int CNT_W = 16;
  localparam int PSC_W = 5;

  logic             i_clk;
  logic             i_reset;
  logic             i_en;
  logic             i_start;
  logic             i_stop;
  logic             i_one_shot;
  logic [PSC_W-1:0] i_psc;
  logic [CNT_W-1:0] i_reload;
  logic [CNT_W-1:0] i_cmp;
  logic             i_clr_flag;
  logic [CNT_W-1:0] o_cnt;
  logic             o_running;
  logic             o_done;
  logic             o_flag;
  logic             o_pwm_out;

  int n_checks;
  int n_err;

  // Reference model state (plain integers)
  int m_cnt;
  int m_pcnt;
  int m_psc_prev;
  int m_running;
  int m_done;
  int m_flag;
  int m_pwm;

  int done_seen;
  int pwm_seen;

  multi_mode_timer #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (i_en),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_one_shot (i_one_shot),
    .i_psc      (i_psc),
    .i_reload   (i_reload),
    .i_cmp      (i_cmp),
    .i_clr_flag (i_clr_flag),
    .o_cnt      (o_cnt),
    .o_running  (o_running),
    .o_done     (o_done),
    .o_flag     (o_flag),
    .o_pwm_out  (o_pwm_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pcnt = 0; m_psc_prev = 0;
    m_running = 0; m_done = 0; m_flag = 0; m_pwm = 0;
  endtask

  // One clock of timer behaviour, from the input values present at the edge.
  task automatic model_step();
    int psc     = int'(i_psc);
    int reload  = int'(i_reload);
    int changed = (psc != m_psc_prev);
    int expired = 0;
    int pwm_nxt = (m_running != 0) && (m_cnt < int'(i_cmp));
    if (i_start) begin
      m_running = 1;
      m_cnt     = reload;
      m_pcnt    = 0;
    end else begin
      if (changed) m_pcnt = 0;
      if (i_stop) begin
        m_running = 0;
      end else if (!changed && m_running != 0 && i_en) begin
        if (m_pcnt == psc) begin
          m_pcnt = 0;
          if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
          end else begin
            expired = 1;
            if (i_one_shot) m_running = 0;
            else            m_cnt = reload;
          end
        end else begin
          m_pcnt = m_pcnt + 1;
        end
      end
    end
    m_done = expired;
    if (expired)         m_flag = 1;
    else if (i_clr_flag) m_flag = 0;
    m_psc_prev = psc;
`ifdef TIMER_PWM_EN
    m_pwm = pwm_nxt;
`else
    m_pwm = 0;
`endif
  endtask

  task automatic step();
    @(posedge i_clk);
    model_step();
    #1;
    chk("cnt",     32'(o_cnt),     32'(m_cnt));
    chk("running", 32'(o_running), 32'(m_running));
    chk("done",    32'(o_done),    32'(m_done));
    chk("flag",    32'(o_flag),    32'(m_flag));
    chk("pwm",     32'(o_pwm_out), 32'(m_pwm));
    if (o_done)    done_seen++;
    if (o_pwm_out) pwm_seen++;
    i_start    = 1'b0;
    i_stop     = 1'b0;
    i_clr_flag = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    done_seen = 0; pwm_seen = 0;
    i_reset = 1'b0; i_en = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_one_shot = 1'b0; i_psc = '0; i_reload = '0; i_cmp = '0; i_clr_flag = 1'b0;
    model_reset();
    #3;
    chk("rst_cnt",     32'(o_cnt),     0);
    chk("rst_running", 32'(o_running), 0);
    chk("rst_done",    32'(o_done),    0);
    chk("rst_flag",    32'(o_flag),    0);
    chk("rst_pwm",     32'(o_pwm_out), 0);
    #9 i_reset = 1'b1;

    // Reset asserted between edges while running
    i_reload = 16'd10; i_cmp = 16'd20; i_start = 1'b1;
    step();
    steps(4);
    #2 i_reset = 1'b0;
    #1;
    chk("amid_cnt",     32'(o_cnt),     0);
    chk("amid_running", 32'(o_running), 0);
    chk("amid_done",    32'(o_done),    0);
    chk("amid_flag",    32'(o_flag),    0);
    chk("amid_pwm",     32'(o_pwm_out), 0);
    model_reset();
    #3 i_reset = 1'b1;
    done_seen = 0;
    steps(15);
    chk("amid_no_done", 32'(done_seen), 0);

    // Periodic: psc=4 reload=3 -> done every 20 cycles
    i_psc = 5'd4; i_reload = 16'd3; i_one_shot = 1'b0; i_start = 1'b1;
    step();
    done_seen = 0;
    steps(60);
    chk("per_done3", 32'(done_seen), 3);

    // One-shot with flag clear, then clear coincident with expiry
    i_psc = 5'd0; i_reload = 16'd2; i_one_shot = 1'b1; i_clr_flag = 1'b1; i_start = 1'b1;
    step();
    done_seen = 0;
    steps(3);
    chk("os_done_at3", 32'(o_done), 1);
    steps(5);
    chk("os_done_once", 32'(done_seen), 1);
    chk("os_idle", 32'(o_running), 0);
    i_clr_flag = 1'b1;
    step();
    chk("os_flag_clr", 32'(o_flag), 0);
    i_start = 1'b1;
    step();
    steps(2);
    i_clr_flag = 1'b1;
    step();
    chk("os_set_wins", 32'(o_flag), 1);

    // Pause with en low, start+stop together, prescale change mid-run
    i_psc = 5'd1; i_reload = 16'd5; i_one_shot = 1'b0; i_start = 1'b1;
    step();
    steps(4);
    i_en = 1'b0;
    steps(7);
    i_en = 1'b1;
    steps(15);
    i_start = 1'b1; i_stop = 1'b1;
    step();
    chk("ss_running", 32'(o_running), 1);
    chk("ss_cnt", 32'(o_cnt), 5);
    steps(3);
    i_psc = 5'd3;
    steps(12);
    i_stop = 1'b1;
    steps(4);

    // PWM duty windows
    i_psc = 5'd0; i_reload = 16'd9; i_cmp = 16'd3; i_start = 1'b1;
    step();
    steps(12);
    pwm_seen = 0;
    steps(10);
`ifdef TIMER_PWM_EN
    chk("pwm_3of10", 32'(pwm_seen), 3);
`else
    chk("pwm_3of10", 32'(pwm_seen), 0);
`endif
    i_cmp = 16'd0;
    steps(2);
    pwm_seen = 0;
    steps(10);
    chk("pwm_cmp0", 32'(pwm_seen), 0);
    i_cmp = 16'd12;
    steps(2);
    pwm_seen = 0;
    steps(10);
`ifdef TIMER_PWM_EN
    chk("pwm_cmp12", 32'(pwm_seen), 10);
`else
    chk("pwm_cmp12", 32'(pwm_seen), 0);
`endif

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      i_en       = ($urandom_range(0, 7) != 0);
      i_start    = ($urandom_range(0, 39) == 0);
      i_stop     = ($urandom_range(0, 59) == 0);
      i_clr_flag = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0)  i_psc      = PSC_W'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)  i_reload   = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0)  i_cmp      = CNT_W'($urandom_range(0, 8));
      if ($urandom_range(0, 199) == 0) i_one_shot = ~i_one_shot;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
